// File: rtl/afu_mem_responder.sv
// afu_mem_responder
//   Memory-side end of the AFU cacheline read/write request interface.
//   Requests are queued in per-direction FIFOs, a round-robin arbiter grants
//   at most one head per cycle, writes update a local backing store, and reads
//   return data through a fixed-latency pipeline. Write completions go out on
//   channel 0 unless a read response occupies that cycle, then on channel 1.
//
//   Optional build macro: RSP_JITTER_EN -- adds a 16-bit LFSR that suppresses
//   arbitration in cycles where lfsr[1:0]==2'b00, modelling variable latency.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   rd_req_addr/mdata/en             read request (cacheline address, tag)
//   rd_req_almostfull                read FIFO near full (registered)
//   rd_rsp_valid/mdata/data          read response
//   wr_req_addr/mdata/data/en        write request
//   wr_req_almostfull                write FIFO near full (registered)
//   wr_rsp0_valid/mdata              write completion, channel 0
//   wr_rsp1_valid/mdata              write completion, channel 1
//   overflow                         sticky: push into a full FIFO
module afu_mem_responder #(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int AF_MARGIN       = 4,
  parameter int RD_LATENCY      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   overflow
);

  localparam int FD   = 1 << FIFO_DEPTH_LOG2;
  localparam int CW   = FIFO_DEPTH_LOG2 + 1;
  // stage 0 is the registered memory read, stages 1..NSTG-1 are the delay line
  localparam int NSTG = RD_LATENCY - 2;
  localparam logic [0:0] PTR_RD = 1'b0;
  localparam logic [0:0] PTR_WR = 1'b1;

  // Only the low address bits index the store; the rest wrap around.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{rd_req_addr[ADDR_LMT-1:MEM_DEPTH_LOG2],
                            wr_req_addr[ADDR_LMT-1:MEM_DEPTH_LOG2]};

  logic [CACHE_WIDTH-1:0]    mem [2**MEM_DEPTH_LOG2];

  logic [MEM_DEPTH_LOG2-1:0] rd_fifo_idx   [FD];
  logic [MDATA-1:0]          rd_fifo_mdata [FD];
  logic [MEM_DEPTH_LOG2-1:0] wr_fifo_idx   [FD];
  logic [MDATA-1:0]          wr_fifo_mdata [FD];
  logic [CACHE_WIDTH-1:0]    wr_fifo_data  [FD];

  logic [FIFO_DEPTH_LOG2-1:0] rd_wp, rd_rp, wr_wp, wr_rp;
  logic [CW-1:0]              rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
  logic                       rd_push, wr_push, gnt_rd, gnt_wr;
  logic                       rd_ne, wr_ne, stall, contended;
  logic [0:0]                 arb_ptr;

  logic                   stg_valid [NSTG];
  logic [MDATA-1:0]       stg_mdata [NSTG];
  logic [CACHE_WIDTH-1:0] stg_data  [NSTG];
  logic                   last_valid;

`ifdef RSP_JITTER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign rd_ne   = (rd_cnt != '0);
  assign wr_ne   = (wr_cnt != '0);
  // A push into a full FIFO is dropped even if the head pops this cycle.
  assign rd_push = rd_req_en && (rd_cnt != CW'(FD));
  assign wr_push = wr_req_en && (wr_cnt != CW'(FD));
  assign contended = rd_ne && wr_ne && !stall;

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (!stall) begin
      if (rd_ne && wr_ne) begin
        if (arb_ptr == PTR_WR) gnt_wr = 1'b1;
        else                   gnt_rd = 1'b1;
      end else if (rd_ne) begin
        gnt_rd = 1'b1;
      end else if (wr_ne) begin
        gnt_wr = 1'b1;
      end
    end
  end

  assign rd_cnt_nxt = rd_cnt + CW'(rd_push) - CW'(gnt_rd);
  assign wr_cnt_nxt = wr_cnt + CW'(wr_push) - CW'(gnt_wr);
  assign last_valid = stg_valid[NSTG-1];

  // Storage without reset: memory contents survive reset by design.
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_fifo_idx[rd_wp]   <= rd_req_addr[MEM_DEPTH_LOG2-1:0];
      rd_fifo_mdata[rd_wp] <= rd_req_mdata;
    end
    if (wr_push) begin
      wr_fifo_idx[wr_wp]   <= wr_req_addr[MEM_DEPTH_LOG2-1:0];
      wr_fifo_mdata[wr_wp] <= wr_req_mdata;
      wr_fifo_data[wr_wp]  <= wr_req_data;
    end
    if (gnt_wr) mem[wr_fifo_idx[wr_rp]] <= wr_fifo_data[wr_rp];
    if (gnt_rd) stg_data[0] <= mem[rd_fifo_idx[rd_rp]];
    for (int i = 1; i < NSTG; i++) stg_data[i] <= stg_data[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wp             <= '0;
      rd_rp             <= '0;
      rd_cnt            <= '0;
      wr_wp             <= '0;
      wr_rp             <= '0;
      wr_cnt            <= '0;
      arb_ptr           <= PTR_WR;
      rd_req_almostfull <= 1'b0;
      wr_req_almostfull <= 1'b0;
      overflow          <= 1'b0;
      for (int i = 0; i < NSTG; i++) begin
        stg_valid[i] <= 1'b0;
        stg_mdata[i] <= '0;
      end
      rd_rsp_valid      <= 1'b0;
      rd_rsp_mdata      <= '0;
      rd_rsp_data       <= '0;
      wr_rsp0_valid     <= 1'b0;
      wr_rsp0_mdata     <= '0;
      wr_rsp1_valid     <= 1'b0;
      wr_rsp1_mdata     <= '0;
    end else begin
      if (rd_push) rd_wp <= rd_wp + FIFO_DEPTH_LOG2'(1);
      if (gnt_rd)  rd_rp <= rd_rp + FIFO_DEPTH_LOG2'(1);
      if (wr_push) wr_wp <= wr_wp + FIFO_DEPTH_LOG2'(1);
      if (gnt_wr)  wr_rp <= wr_rp + FIFO_DEPTH_LOG2'(1);
      rd_cnt <= rd_cnt_nxt;
      wr_cnt <= wr_cnt_nxt;
      rd_req_almostfull <= (rd_cnt_nxt >= CW'(FD - AF_MARGIN));
      wr_req_almostfull <= (wr_cnt_nxt >= CW'(FD - AF_MARGIN));
      if ((rd_req_en && !rd_push) || (wr_req_en && !wr_push)) overflow <= 1'b1;
      if (contended) arb_ptr <= ~arb_ptr;

      stg_valid[0] <= gnt_rd;
      stg_mdata[0] <= gnt_rd ? rd_fifo_mdata[rd_rp] : '0;
      for (int i = 1; i < NSTG; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_mdata[i] <= stg_mdata[i-1];
      end

      rd_rsp_valid <= last_valid;
      rd_rsp_mdata <= last_valid ? stg_mdata[NSTG-1] : '0;
      rd_rsp_data  <= last_valid ? stg_data[NSTG-1]  : '0;

      // last_valid becomes rd_rsp_valid at this same edge, so a completion
      // issued now shares its cycle with that read response.
      wr_rsp0_valid <= gnt_wr && !last_valid;
      wr_rsp0_mdata <= (gnt_wr && !last_valid) ? wr_fifo_mdata[wr_rp] : '0;
      wr_rsp1_valid <= gnt_wr && last_valid;
      wr_rsp1_mdata <= (gnt_wr && last_valid) ? wr_fifo_mdata[wr_rp] : '0;
    end
  end

endmodule

// File: tb/tb_afu_mem_responder.sv
module tb_afu_mem_responder;

  localparam int AW = 20;
  localparam int MW = 14;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_req_addr, wr_req_addr;
  logic [MW-1:0] rd_req_mdata, wr_req_mdata;
  logic [DW-1:0] wr_req_data;
  logic          rd_req_en, wr_req_en;
  logic          rd_req_almostfull, wr_req_almostfull, overflow;
  logic          rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid;
  logic [MW-1:0] rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [DW-1:0] rd_rsp_data;

  afu_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [MW-1:0] mdata;
    logic [DW-1:0] data;
    int            due;
    int            ch;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  logic [DW-1:0] shadow [1024];

  // spec-level occupancy/arbiter model
  int m_rd_occ, m_wr_occ, rd_accepted, rd_rsp_cnt;
  bit m_ptr_wr, m_ovf;

  task automatic model_reset();
    m_rd_occ = 0; m_wr_occ = 0; m_ptr_wr = 1'b1; m_ovf = 1'b0;
    rd_q.delete(); wr_q.delete();
  endtask

  // One cycle of stimulus; rlat/wlat > 0 pins the expected response cycle.
  task automatic step(input bit re, input int ra, input int rm, input int rlat,
                      input bit we, input int wa, input int wm, input logic [DW-1:0] wd,
                      input int wlat, input int wch);
    exp_t e;
    bit rne, wne, rg, wg;
    rd_req_en = re; rd_req_addr = AW'(ra); rd_req_mdata = MW'(rm);
    wr_req_en = we; wr_req_addr = AW'(wa); wr_req_mdata = MW'(wm); wr_req_data = wd;
    rne = m_rd_occ > 0; wne = m_wr_occ > 0; rg = 0; wg = 0;
    if (rne && wne) begin
      if (m_ptr_wr) wg = 1; else rg = 1;
      m_ptr_wr = !m_ptr_wr;
    end else if (rne) rg = 1;
    else if (wne) wg = 1;
    if (re) begin
      if (m_rd_occ < 16) begin
        e.mdata = MW'(rm); e.data = shadow[ra % 1024];
        e.due = (rlat > 0) ? cyc + rlat : -1; e.ch = -1;
        rd_q.push_back(e); m_rd_occ++; rd_accepted++;
      end else m_ovf = 1'b1;
    end
    if (we) begin
      if (m_wr_occ < 16) begin
        shadow[wa % 1024] = wd;
        e.mdata = MW'(wm); e.data = '0;
        e.due = (wlat > 0) ? cyc + wlat : -1; e.ch = wch;
        wr_q.push_back(e); m_wr_occ++;
      end else m_ovf = 1'b1;
    end
    if (rg) m_rd_occ--;
    if (wg) m_wr_occ--;
    @(posedge clk); #1;
    chk("rd_almostfull", DW'(rd_req_almostfull), DW'(m_rd_occ >= 12));
    chk("wr_almostfull", DW'(wr_req_almostfull), DW'(m_wr_occ >= 12));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    rd_req_en = 1'b0; wr_req_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0, 0, -1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (rd_q.size() != 0 || wr_q.size() != 0); i++) idle(1);
    chk("drain_pending", DW'(rd_q.size() + wr_q.size()), DW'(0));
    idle(2);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_flags"}, DW'({rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid,
                             rd_req_almostfull, wr_req_almostfull, overflow}), DW'(0));
    chk({tag, "_mdata"}, DW'({rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata}), DW'(0));
    chk({tag, "_data"}, rd_rsp_data, DW'(0));
  endtask

  task automatic async_reset();
    #1 reset_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // Response checker
  always @(negedge clk) begin
    if (reset_n) begin
      exp_t e;
      total++;
      assert (!(wr_rsp0_valid && wr_rsp1_valid)) else begin
        bad++; $error("FAIL wr_both_channels observed=1 expected=0");
      end
      if (rd_rsp_valid) begin
        rd_rsp_cnt++;
        total++;
        assert (rd_q.size() != 0) else begin
          bad++; $error("FAIL rd_unexpected observed mdata=%0h expected=none", rd_rsp_mdata);
        end
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("rd_mdata", DW'(rd_rsp_mdata), DW'(e.mdata));
          chk("rd_data", rd_rsp_data, e.data);
          if (e.due >= 0) chk("rd_cycle", DW'(cyc), DW'(e.due));
        end
      end else begin
        chk("rd_idle_zero", {rd_rsp_data[DW-1:MW], rd_rsp_data[MW-1:0] | rd_rsp_mdata}, DW'(0));
      end
      if (wr_rsp0_valid || wr_rsp1_valid) begin
        total++;
        assert (wr_q.size() != 0) else begin
          bad++; $error("FAIL wr_unexpected observed ch1=%0b expected=none", wr_rsp1_valid);
        end
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("wr_mdata", DW'(wr_rsp1_valid ? wr_rsp1_mdata : wr_rsp0_mdata), DW'(e.mdata));
          if (e.ch >= 0) chk("wr_channel", DW'(wr_rsp1_valid), DW'(e.ch));
          else           chk("wr_channel_rule", DW'(wr_rsp1_valid), DW'(rd_rsp_valid));
          if (e.due >= 0) chk("wr_cycle", DW'(cyc), DW'(e.due));
        end
      end
    end
  end

  initial begin
    int cnt0, acc0;
    reset_n = 1'b0;
    rd_req_en = 1'b0; wr_req_en = 1'b0;
    rd_req_addr = '0; rd_req_mdata = '0;
    wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
    rd_accepted = 0; rd_rsp_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset_state");
    reset_n = 1'b1;

    // preload 0..7
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, i, 16'h100 + i, {16{32'hC0DE0000 + i}}, 2, 0);
    drain();

    // write then read 2 cycles later
    step(0, 0, 0, 0, 1, 5, 14'h011, {64{8'hA5}}, 2, 0);
    idle(1);
    step(1, 5, 14'h022, 4, 0, 0, 0, '0, 0, -1);
    drain();

    // 8 back-to-back reads: consecutive due cycles mean no bubbles
    for (int i = 0; i < 8; i++) step(1, i, 14'h030 + i, 4, 0, 0, 0, '0, 0, -1);
    drain();

    // address wrap: 0x400 lands on index 0
    step(0, 0, 0, 0, 1, 20'h00400, 14'h040, {16{32'h5A5A0400}}, 2, 0);
    drain();
    step(1, 0, 14'h041, 4, 0, 0, 0, '0, 0, -1);
    drain();

    // write completion coinciding with a read response goes to channel 1
    step(1, 1, 14'h050, 4, 0, 0, 0, '0, 0, -1);
    idle(1);
    step(0, 0, 0, 0, 1, 700, 14'h051, {16{32'h07000700}}, 2, 1);
    drain();

    // simultaneous read+write pairs from a fresh pointer: W,R,W,R,...
    async_reset();
    for (int i = 0; i < 4; i++)
      step(1, i, 14'h060 + i, 5 + i, 1, 800 + i, 14'h070 + i, {16{32'hB0000000 + i}}, 2 + i, 0);
    drain();

    // read FIFO overrun under a competing write stream
    cnt0 = rd_rsp_cnt; acc0 = rd_accepted;
    for (int i = 0; i < 40; i++)
      step(1, i % 8, 14'h100 + i, 0, 1, 600 + i, 14'h200 + i, {16{32'hD0000000 + i}}, 0, -1);
    drain();
    chk("overflow_sticky", DW'(overflow), DW'(1));
    chk("rd_rsp_count", DW'(rd_rsp_cnt - cnt0), DW'(rd_accepted - acc0));

    // reset with reads in flight: nothing comes back, memory survives
    step(1, 2, 14'h300, 0, 0, 0, 0, '0, 0, -1);
    step(1, 3, 14'h301, 0, 0, 0, 0, '0, 0, -1);
    step(1, 4, 14'h302, 0, 0, 0, 0, '0, 0, -1);
    async_reset();
    idle(12);
    step(1, 5, 14'h303, 4, 0, 0, 0, '0, 0, -1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
